// File: rtl/game_pkg.sv
// Shared Minesweeper types: cell layout, board size, bus packing and the
// board_mem sequencing states.
package game_pkg;

  localparam int MAX_DIM = 16;

  // MSB-first field order gives {mine_ind, revealed, defused, mine}, LSB = mine
  typedef struct packed {
    logic [3:0] mine_ind;
    logic       revealed;
    logic       defused;
    logic       mine;
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PLACE,
    ST_COUNT,
    ST_READY
  } bm_state_t;

  function automatic logic [15:0] pack_cell(input cell_t c);
    return {9'b0, c};
  endfunction

  function automatic cell_t unpack_cell(input logic [6:0] d);
    return cell_t'(d);
  endfunction

endpackage

// File: rtl/mine_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) used to pick mine positions.
module mine_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] lfsr
);

  localparam logic [15:0] TAPS = 16'hB400;

  // Advance one step per enabled cycle; the seed is only loaded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/board_mem.sv
// Minesweeper cell array: builds a board (clear, place mines, count
// neighbours), applies reveal/flag commands and serves cells over Wishbone.
// Cell addressing is {row[3:0], col[3:0]}, so the array is 16x16.
module board_mem #(
  parameter int          MAX_DIM   = game_pkg::MAX_DIM,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  dim,
  input  logic [7:0]  mine_num,
  input  logic        cmd_valid,
  input  logic        cmd_reveal,
  input  logic [3:0]  cmd_row,
  input  logic [3:0]  cmd_col,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        ready,
  output logic        mine_hit,
  output logic [7:0]  flag_cnt
);

  import game_pkg::*;

  localparam int NCELL = MAX_DIM * MAX_DIM;

  cell_t       board [NCELL];
  bm_state_t   state;
  logic [7:0]  idx;
  logic [4:0]  dim_q;
  logic [7:0]  eff_mines;
  logic [7:0]  placed;
  logic [15:0] lfsr;

  logic [9:0]  dim_sq;
  logic [9:0]  dim_sq_m1;
  logic [7:0]  eff_next;
  logic [7:0]  cand_idx;
  logic        cand_ok;
  logic        idx_in_dim;
  logic [3:0]  nb_cnt;
  logic [7:0]  cmd_idx;
  logic        cmd_hit;
  logic        wb_req;
  logic        wb_wr;
  logic        unused_bits;

  mine_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_PLACE),
    .lfsr (lfsr)
  );

  // Clamp the requested mine count so at least one cell stays safe
  always_comb begin
    dim_sq    = 10'(dim) * 10'(dim);
    dim_sq_m1 = dim_sq - 10'd1;
    if (dim == 5'd0) begin
      eff_next = 8'd0;
    end else if ({2'b00, mine_num} < dim_sq_m1) begin
      eff_next = mine_num;
    end else begin
      eff_next = dim_sq_m1[7:0];
    end
  end

  // Placement candidate from the LFSR low byte: row = [7:4], col = [3:0]
  always_comb begin
    cand_idx = lfsr[7:0];
    cand_ok  = ({1'b0, lfsr[7:4]} < dim_q) && ({1'b0, lfsr[3:0]} < dim_q) &&
               !board[cand_idx].mine;
  end

  // Neighbour mine count for the cell being swept; off-board neighbours add 0
  always_comb begin
    int r;
    int c;
    nb_cnt     = 4'd0;
    idx_in_dim = ({1'b0, idx[7:4]} < dim_q) && ({1'b0, idx[3:0]} < dim_q);
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = int'(idx[7:4]) + dr;
        c = int'(idx[3:0]) + dc;
        if (!(dr == 0 && dc == 0) && r >= 0 && c >= 0 &&
            r < int'(dim_q) && c < int'(dim_q)) begin
          nb_cnt = nb_cnt + {3'b000, board[8'(r * 16 + c)].mine};
        end
      end
    end
  end

  // Command and bus qualification; a command to the same cell beats a write
  always_comb begin
    cmd_idx = {cmd_row, cmd_col};
    cmd_hit = (state == ST_READY) && !start && cmd_valid &&
              ({1'b0, cmd_row} < dim_q) && ({1'b0, cmd_col} < dim_q);
    wb_req  = wb_cyc_i && wb_stb_i && !wb_ack_o;
    wb_wr   = wb_req && wb_we_i && (state == ST_READY) && !start &&
              !(cmd_hit && (cmd_idx == wb_adr_i));
  end

  assign unused_bits = ^{wb_dat_i[15:7], lfsr[15:8]};

  // Board sequencer, array storage, command handling and Wishbone response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 8'd0;
      dim_q     <= 5'd0;
      eff_mines <= 8'd0;
      placed    <= 8'd0;
      ready     <= 1'b0;
      mine_hit  <= 1'b0;
      flag_cnt  <= 8'd0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= 16'h0000;
      for (int i = 0; i < NCELL; i++) begin
        board[i] <= '0;
      end
    end else begin
      mine_hit <= 1'b0;
      wb_ack_o <= wb_req;
      if (wb_req) begin
        wb_dat_o <= pack_cell(board[wb_adr_i]);
      end

      if (start) begin
        state     <= ST_CLEAR;
        idx       <= 8'd0;
        placed    <= 8'd0;
        dim_q     <= dim;
        eff_mines <= eff_next;
        flag_cnt  <= 8'd0;
        ready     <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_CLEAR: begin
            board[idx] <= '0;
            idx        <= idx + 8'd1;
            if (idx == 8'hFF) begin
              state <= ST_PLACE;
            end
          end
          ST_PLACE: begin
            if (placed == eff_mines) begin
              state <= ST_COUNT;
              idx   <= 8'd0;
            end else if (cand_ok) begin
              board[cand_idx].mine <= 1'b1;
              placed               <= placed + 8'd1;
            end
          end
          ST_COUNT: begin
            if (idx_in_dim) begin
              board[idx].mine_ind <= nb_cnt;
              board[idx].revealed <= 1'b0;
              board[idx].defused  <= 1'b0;
            end else begin
              board[idx] <= '0;
            end
            idx <= idx + 8'd1;
            if (idx == 8'hFF) begin
              state <= ST_READY;
              ready <= 1'b1;
            end
          end
          ST_READY: begin
            if (wb_wr) begin
              board[wb_adr_i] <= unpack_cell(wb_dat_i[6:0]);
            end
            if (cmd_hit) begin
              if (cmd_reveal) begin
                board[cmd_idx].revealed <= 1'b1;
                mine_hit                <= board[cmd_idx].mine;
              end else if (!board[cmd_idx].revealed) begin
                board[cmd_idx].defused <= !board[cmd_idx].defused;
                if (board[cmd_idx].defused) begin
                  flag_cnt <= flag_cnt - 8'd1;
                end else begin
                  flag_cnt <= flag_cnt + 8'd1;
                end
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_mem.sv
// Directed bench for board_mem: board build, neighbour counts, flag/reveal
// commands, mine-count clamp, restart mid-build, write/command collision.
module tb_board_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  dim = 5'd0;
  logic [7:0]  mine_num = 8'd0;
  logic        cmd_valid = 1'b0;
  logic        cmd_reveal = 1'b0;
  logic [3:0]  cmd_row = 4'd0;
  logic [3:0]  cmd_col = 4'd0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [7:0]  wb_adr_i = 8'd0;
  logic [15:0] wb_dat_i = 16'h0000;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;
  logic        ready;
  logic        mine_hit;
  logic [7:0]  flag_cnt;

  int          n_checks = 0;
  int          n_err = 0;
  int          ack_bad = 0;
  logic [15:0] mem [256];

  board_mem #(
    .MAX_DIM   (16),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dim        (dim),
    .mine_num   (mine_num),
    .cmd_valid  (cmd_valid),
    .cmd_reveal (cmd_reveal),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .ready      (ready),
    .mine_hit   (mine_hit),
    .flag_cnt   (flag_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [15:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
    tick();
    if (wb_ack_o !== 1'b1) ack_bad++;
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    if (wb_ack_o !== 1'b0) ack_bad++;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [15:0] wd, output logic [15:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = wd;
    tick();
    if (wb_ack_o !== 1'b1) ack_bad++;
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tick();
    if (wb_ack_o !== 1'b0) ack_bad++;
  endtask

  task automatic do_cmd(input logic rev, input logic [3:0] r, input logic [3:0] c);
    cmd_valid = 1'b1; cmd_reveal = rev; cmd_row = r; cmd_col = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] d, input logic [7:0] m);
    dim = d; mine_num = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, ready, 1'b1);
  endtask

  task automatic read_all();
    for (int a = 0; a < 256; a++) begin
      wb_read(8'(a), mem[a]);
    end
  endtask

  function automatic int nb_model(input int r, input int c, input int d);
    int n;
    n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && c + dc >= 0 &&
            r + dr < d && c + dc < d)
          n += int'(mem[(r + dr) * 16 + (c + dc)][0]);
    return n;
  endfunction

  // Fresh board: mine total, nothing outside dim x dim, every cell exact
  task automatic verify_board(input string tag, input int d, input int mines);
    int nm;
    int outside;
    logic [15:0] exp;
    nm = 0;
    outside = 0;
    for (int a = 0; a < 256; a++) begin
      if ((a / 16) < d && (a % 16) < d) nm += int'(mem[a][0]);
      else if (mem[a] != 16'h0000) outside++;
    end
    check({tag, "_mines"}, nm, mines);
    check({tag, "_outside"}, outside, 0);
    for (int r = 0; r < d; r++)
      for (int c = 0; c < d; c++) begin
        exp = 16'((nb_model(r, c, d) << 3) | int'(mem[r * 16 + c][0]));
        check($sformatf("%s_cell_%0d_%0d", tag, r, c), mem[r * 16 + c], exp);
      end
  endtask

  initial begin
    logic [15:0] d;
    int s_idx;
    int m_idx;
    int f_idx;
    int rdy_seen;

    // Reset
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", ready, 1'b0);
    check("rst_mine_hit", mine_hit, 1'b0);
    check("rst_flag_cnt", flag_cnt, 8'd0);
    check("rst_ack", wb_ack_o, 1'b0);
    check("rst_dat", wb_dat_o, 16'h0000);
    wb_read(8'h23, d);
    check("idle_read", d, 16'h0000);

    // dim=9, 10 mines
    do_start(5'd9, 8'd10);
    check("start_ready_low", ready, 1'b0);
    wait_ready("ready_9x9", 8000);
    read_all();
    verify_board("b9", 9, 10);

    s_idx = -1; m_idx = -1; f_idx = -1;
    for (int a = 0; a < 256; a++) begin
      if ((a / 16) < 9 && (a % 16) < 9) begin
        if (mem[a][0] && m_idx < 0) m_idx = a;
        if (!mem[a][0] && s_idx < 0) s_idx = a;
        if (!mem[a][0]) f_idx = a;
      end
    end

    // Flag toggle on (2,2)
    do_cmd(1'b0, 4'd2, 4'd2);
    check("flag1_cnt", flag_cnt, 8'd1);
    wb_read(8'h22, d);
    check("flag1_bit", d[1], 1'b1);
    do_cmd(1'b0, 4'd2, 4'd2);
    check("flag2_cnt", flag_cnt, 8'd0);
    wb_read(8'h22, d);
    check("flag2_bit", d[1], 1'b0);

    // Reveal safe cell, then flagging it has no effect
    do_cmd(1'b1, 4'(s_idx / 16), 4'(s_idx % 16));
    check("reveal_safe_hit", mine_hit, 1'b0);
    wb_read(8'(s_idx), d);
    check("reveal_safe_cell", d, mem[s_idx] | 16'h0004);
    do_cmd(1'b0, 4'(s_idx / 16), 4'(s_idx % 16));
    check("flag_revealed_cnt", flag_cnt, 8'd0);
    wb_read(8'(s_idx), d);
    check("flag_revealed_cell", d, mem[s_idx] | 16'h0004);

    // Reveal a mine: one-cycle pulse
    do_cmd(1'b1, 4'(m_idx / 16), 4'(m_idx % 16));
    check("mine_hit_pulse", mine_hit, 1'b1);
    tick();
    check("mine_hit_drop", mine_hit, 1'b0);
    wb_read(8'(m_idx), d);
    check("reveal_mine_cell", d, mem[m_idx] | 16'h0004);

    // Out-of-range commands ignored
    do_cmd(1'b1, 4'd12, 4'd0);
    check("oor_reveal_hit", mine_hit, 1'b0);
    wb_read(8'hC0, d);
    check("oor_reveal_cell", d, 16'h0000);
    do_cmd(1'b0, 4'd0, 4'd12);
    check("oor_flag_cnt", flag_cnt, 8'd0);

    // Plain write in READY, pre-write data on the ack
    wb_write(8'hFF, 16'h0055, d);
    check("wr_prev", d, 16'h0000);
    wb_read(8'hFF, d);
    check("wr_readback", d, 16'h0055);

    // Write and flag to the same cell in the same cycle: command wins
    cmd_valid = 1'b1; cmd_reveal = 1'b0;
    cmd_row = 4'(f_idx / 16); cmd_col = 4'(f_idx % 16);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 8'(f_idx); wb_dat_i = 16'h007D;
    tick();
    check("collide_prev", wb_dat_o, mem[f_idx]);
    cmd_valid = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tick();
    check("collide_cnt", flag_cnt, 8'd1);
    wb_read(8'(f_idx), d);
    check("collide_cell", d, mem[f_idx] | 16'h0002);

    // Clamp: dim=2 with 200 requested -> 3 mines
    do_start(5'd2, 8'd200);
    check("restart_ready_low", ready, 1'b0);
    check("restart_flag_clr", flag_cnt, 8'd0);
    wait_ready("ready_2x2", 8000);
    read_all();
    verify_board("b2", 2, 3);

    // Restart mid-COUNT: dim=1, no mines -> CLEAR 256 + PLACE 1 + COUNT 256
    do_start(5'd1, 8'd0);
    wb_read(8'h11, d);
    rdy_seen = 0;
    for (int i = 0; i < 298; i++) begin
      tick();
      if (ready === 1'b1) rdy_seen++;
    end
    do_start(5'd3, 8'd2);
    check("midcount_ready_low", ready, 1'b0);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ready === 1'b1) rdy_seen++;
    end
    check("midcount_no_ready", rdy_seen, 0);
    wait_ready("ready_3x3", 8000);
    read_all();
    verify_board("b3", 3, 2);

    check("ack_width", ack_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/board_mem.md
Name: board_mem

Overview:
- Owns the Minesweeper cell array and serves it as a Wishbone slave to the board renderer's game_board port, so it sits directly upstream of the renderer.
- On a start request it clears the array and places mines at pseudo-random positions using an LFSR. It then computes each cell's neighbour-mine count and accepts reveal and flag commands from game logic.
- The board is square: rows = columns = dim, with 1..MAX_DIM.

Parameters:
MAX_DIM, 16, maximum rows/columns; the array is MAX_DIM x MAX_DIM registers.
LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be non-zero.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; (re)initialise the board
dim  in  5  board dimension 1..16, sampled on start
mine_num  in  8  requested mine count, sampled on start
cmd_valid  in  1  command strobe, honoured only in READY
cmd_reveal  in  1  1 = reveal cell, 0 = toggle flag
cmd_row  in  4  command row
cmd_col  in  4  command column
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  Wishbone write enable
wb_adr_i  in  8  {row[3:0], col[3:0]}
wb_dat_i  in  16  write data, packed cell
wb_dat_o  out  16  read data, packed cell
wb_ack_o  out  1  Wishbone acknowledge
ready  out  1  board initialised, commands accepted
mine_hit  out  1  one-cycle pulse: a mined cell was revealed
flag_cnt  out  8  number of cells currently flagged (defused)

Behaviour:
- Cell type (game_pkg) fields: mine, defused (flag), revealed, mine_ind[3:0] (0..8).
- Packed onto the 16-bit bus as {9'b0, mine_ind, revealed, defused, mine}, LSB = mine.

Reset values:
- ready=0, mine_hit=0, flag_cnt=0, wb_ack_o=0, wb_dat_o=0.
- Entire array zero, LFSR=LFSR_SEED, state IDLE.

State machine:
- IDLE: wait for start.
- CLEAR: zero one cell per cycle, linear index 0..255; 256 cycles, then go to PLACE.
- PLACE: LFSR steps every cycle (taps 16,14,13,11). Candidate cell = lfsr[7:4] row, lfsr[3:0] col.
  - Accept if row<dim, col<dim and the cell is not already a mine; set mine and increment the placed counter.
  - Leave when placed == eff_mines.
  - eff_mines = min(mine_num, dim*dim-1), so at least one safe cell always exists and PLACE always terminates.
  - mine_num=0: PLACE is left on its first cycle.
- COUNT: one cell per cycle, linear index 0..255.
  - mine_ind = number of the 8 neighbours with mine=1 that lie inside dim x dim.
  - Out-of-range neighbours, including row/col -1, contribute 0; cells outside dim are written 0.
  - 256 cycles, then go to READY.
- READY: ready=1. Stay until the next start.

Start handling:
- start in any state, including mid-CLEAR/PLACE/COUNT, goes to CLEAR next cycle.
- ready drops the cycle after start.
- dim and mine_num are re-sampled; flag_cnt is cleared.
- The LFSR is not reseeded, so successive boards differ.

Commands (READY only; ignored elsewhere):
- Reveal: set revealed. If the cell is a mine, mine_hit pulses in the cycle after cmd_valid.
- Flag: toggle defused unless the cell is revealed; flag_cnt +1/-1 accordingly.
- Either command with row>=dim or col>=dim is ignored.
- Array updates are visible the cycle after cmd_valid.

Wishbone:
- Classic single-beat transfer. wb_ack_o asserts the cycle after cyc&stb&!ack and stays high for exactly 1 cycle.
- wb_dat_o is registered with the ack and carries the pre-write cell value.
- Reads are acked in every state and return the current array contents.
- Writes update the cell only in READY; in other states they are acked but discarded.
- Write and command to the same cell in the same cycle: the command wins and the write is dropped.

Decomposition:
- game_pkg: cell struct, MAX_DIM, Wishbone cell-packing function, board_mem state enum.
- Sub-module mine_lfsr (16-bit Galois LFSR, seed parameter, enable input) used by PLACE.
- The neighbour counter stays inline, as combinational logic over the register array.

Test Plan:
1. Reset, start with dim=9, mine_num=10 -> ready rises within 256+PLACE+256 cycles; exactly 10 cells have mine=1, all with row,col<9.
2. After case 1, read every address over Wishbone -> each mine_ind equals a bench-computed neighbour count; cells outside 9x9 read 16'h0000; ack is 1 cycle wide.
3. Flag toggle on (2,2) twice, then on a revealed cell -> flag_cnt 1, 0, 0; defused bit follows.
4. Reveal a known mine -> mine_hit one-cycle pulse, revealed=1. Reveal a safe cell -> no pulse. Reveal at row=12 with dim=9 -> ignored.
5. dim=2, mine_num=200 -> exactly 3 mines; ready asserts (clamp, no hang).
6. start asserted mid-COUNT -> ready stays 0, board rebuilt; WB write in the same cycle as a flag command to the same cell in READY -> command result kept.
